// File: rtl/irq_pad_ctrl_if.sv
// Core-facing handshake bundle for irq_pad_ctrl: interrupt presentation and EOI.
// master = the interrupt controller, slave = the core.
interface irq_pad_ctrl_if #(
   parameter int IDW = 4
) ();
   logic           irq_valid;
   logic [IDW-1:0] irq_id;
   logic           irq_ready;
   logic           eoi_valid;
   logic [IDW-1:0] eoi_id;
   logic           eoi_ready;

   modport master (
      output irq_valid, irq_id, eoi_ready,
      input  irq_ready, eoi_valid, eoi_id
   );

   modport slave (
      input  irq_valid, irq_id, eoi_ready,
      output irq_ready, eoi_valid, eoi_id
   );
endinterface

// File: rtl/irq_pad_ctrl.sv
// Interrupt pad front-end: pad synchronisation, polarity/edge normalisation, fixed-priority
// dispatch over a valid/ready handshake, and EOI handshakes turned into fixed-width pad pulses.
module irq_pad_ctrl #(
   parameter int N_IRQ            = 16,
   parameter int SYNC_STAGES      = 2,
   parameter int EOI_PULSE_CYCLES = 4,
   parameter int IDW              = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N_IRQ-1:0]  irq_pad_in,
   output logic [N_IRQ-1:0]  eoi_pad_out,
   input  logic [N_IRQ-1:0]  cfg_edge,
   input  logic [N_IRQ-1:0]  cfg_pol,
   input  logic [N_IRQ-1:0]  cfg_mask,
   output logic [N_IRQ-1:0]  pending,
   output logic [N_IRQ-1:0]  in_service,
   irq_pad_ctrl_if.master    bus
);

   localparam int CW = (EOI_PULSE_CYCLES > 0) ? $clog2(EOI_PULSE_CYCLES + 1) : 1;
   localparam int WW = $clog2(SYNC_STAGES + 2);
   localparam logic [WW-1:0] WARM_LAST  = WW'(SYNC_STAGES + 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(EOI_PULSE_CYCLES);

   logic [N_IRQ-1:0] sync_r [SYNC_STAGES];
   logic [N_IRQ-1:0] prev_r;
   logic [N_IRQ-1:0] pending_r;
   logic [N_IRQ-1:0] in_service_r;
   logic [N_IRQ-1:0] pad_r;
   logic [CW-1:0]    cnt_r [N_IRQ];
   logic [WW-1:0]    warm_r;
   logic             valid_r;
   logic [IDW-1:0]   id_r;

   logic [N_IRQ-1:0] n_s;
   logic [N_IRQ-1:0] edge_s;
   logic [N_IRQ-1:0] cand_s;
   logic [N_IRQ-1:0] acc_vec_s;
   logic [N_IRQ-1:0] eoi_sel_s;
   logic [N_IRQ-1:0] eoi_vec_s;
   logic [N_IRQ-1:0] pending_next_s;
   logic [N_IRQ-1:0] in_service_next_s;
   logic [N_IRQ-1:0] pad_next_s;
   logic [CW-1:0]    cnt_next_s [N_IRQ];
   logic [IDW-1:0]   win_s;
   logic             accept_s;
   logic             eoi_fire_s;

   // Next-state: edge detection (held off until the synchronisers are primed), priority pick, EOI pulses.
   always_comb begin
      n_s = sync_r[SYNC_STAGES-1] ^ ~cfg_pol;
      if (warm_r == WARM_LAST) begin
         edge_s = n_s & ~prev_r;
      end else begin
         edge_s = {N_IRQ{1'b0}};
      end
      accept_s = valid_r & bus.irq_ready;
      cand_s   = pending_r & cfg_mask & ~in_service_r;
      win_s    = {IDW{1'b0}};
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         win_s = cand_s[i] ? IDW'(i) : win_s;
      end
      for (int i = 0; i < N_IRQ; i++) begin
         eoi_sel_s[i] = (bus.eoi_id == IDW'(i));
         acc_vec_s[i] = accept_s & (id_r == IDW'(i));
      end
      // Out-of-range EOI ids match no channel: accepted, no effect.
      eoi_fire_s        = bus.eoi_valid & ~(|(pad_r & eoi_sel_s));
      eoi_vec_s         = {N_IRQ{eoi_fire_s}} & eoi_sel_s & in_service_r;
      in_service_next_s = (in_service_r & ~eoi_vec_s) | acc_vec_s;
      for (int i = 0; i < N_IRQ; i++) begin
         if (cfg_edge[i]) begin
            pending_next_s[i] = edge_s[i] | (pending_r[i] & ~acc_vec_s[i]);
         end else begin
            pending_next_s[i] = n_s[i];
         end
         if (eoi_vec_s[i]) begin
            cnt_next_s[i] = PULSE_LOAD;
         end else if (cnt_r[i] != {CW{1'b0}}) begin
            cnt_next_s[i] = cnt_r[i] - CW'(1);
         end else begin
            cnt_next_s[i] = {CW{1'b0}};
         end
         pad_next_s[i] = (cnt_next_s[i] != {CW{1'b0}});
      end
   end

   assign bus.eoi_ready = ~(|(pad_r & eoi_sel_s));

   // State registers, including the presentation FSM holding irq_id until accepted.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_r[k] <= {N_IRQ{1'b0}};
         end
         for (int i = 0; i < N_IRQ; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
         prev_r       <= {N_IRQ{1'b0}};
         pending_r    <= {N_IRQ{1'b0}};
         in_service_r <= {N_IRQ{1'b0}};
         pad_r        <= {N_IRQ{1'b0}};
         warm_r       <= {WW{1'b0}};
         valid_r      <= 1'b0;
         id_r         <= {IDW{1'b0}};
      end else begin
         sync_r[0] <= irq_pad_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_r[k] <= sync_r[k-1];
         end
         cnt_r        <= cnt_next_s;
         prev_r       <= n_s;
         pending_r    <= pending_next_s;
         in_service_r <= in_service_next_s;
         pad_r        <= pad_next_s;
         if (warm_r != WARM_LAST) begin
            warm_r <= warm_r + WW'(1);
         end else begin
            warm_r <= warm_r;
         end
         if (valid_r) begin
            valid_r <= ~bus.irq_ready;
         end else if (|cand_s) begin
            valid_r <= 1'b1;
            id_r    <= win_s;
         end else begin
            valid_r <= 1'b0;
         end
      end
   end

   assign bus.irq_valid = valid_r;
   assign bus.irq_id    = id_r;
   assign pending       = pending_r;
   assign in_service    = in_service_r;
   assign eoi_pad_out   = pad_r;

endmodule
